// File: rtl/magcom_arbiter.sv
// magcom_arbiter: round-robin scheduler sharing one 4-bit unsigned magnitude
// comparator among four requesters. A grant captures the winner's operand
// pair; the following cycle produces registered e/g/l flags tagged with the
// requester index.
module magcom_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] a_bus,
    input  logic [15:0] b_bus,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        res_valid,
    output logic [1:0]  res_id,
    output logic        res_e,
    output logic        res_g,
    output logic        res_l
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_cur_id;
    logic [3:0]  r_op_a;
    logic [3:0]  r_op_b;
    logic [3:0]  r_gnt;
    logic        r_busy;
    logic        r_res_valid;
    logic [1:0]  r_res_id;
    logic        r_res_e;
    logic        r_res_g;
    logic        r_res_l;

    logic        w_found;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;
    logic [3:0]  w_sel_a;
    logic [3:0]  w_sel_b;
    logic        w_eq;
    logic        w_gt;
    logic        w_lt;

    // Round-robin search: first set request at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Winner's operand nibbles and the shared unsigned comparator.
    assign w_sel_a = a_bus[{w_winner, 2'b00} +: 4];
    assign w_sel_b = b_bus[{w_winner, 2'b00} +: 4];
    assign w_eq    = (r_op_a == r_op_b);
    assign w_gt    = (r_op_a >  r_op_b);
    assign w_lt    = (r_op_a <  r_op_b);

    // Arbitration FSM with registered grant, busy and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_cur_id    <= 2'd0;
            r_op_a      <= 4'd0;
            r_op_b      <= 4'd0;
            r_gnt       <= 4'b0000;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= 2'd0;
            r_res_e     <= 1'b0;
            r_res_g     <= 1'b0;
            r_res_l     <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= 4'b0001 << w_winner;
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_cur_id <= w_winner;
                        r_busy   <= 1'b1;
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_res_e     <= w_eq;
                    r_res_g     <= w_gt;
                    r_res_l     <= w_lt;
                    r_res_id    <= r_cur_id;
                    r_res_valid <= 1'b1;
                    r_gnt       <= 4'b0000;
                    r_busy      <= 1'b0;
                    r_ptr       <= r_cur_id + 2'd1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_e     = r_res_e;
    assign res_g     = r_res_g;
    assign res_l     = r_res_l;

endmodule

// File: doc/magcom_arbiter.md
# magcom_arbiter

Round-robin scheduler that shares one 4-bit magnitude comparator (equal/greater/less) among four requesters. It captures the granted requester's operand pair, runs the compare, and returns registered e/g/l flags tagged with the requester ID. It sits between requesting blocks and the magnitude-compare datapath, and replaces per-client comparator copies.

## Interface
- Parameters: none. The requester count (4) and operand width (4) are fixed.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  4  level request, one bit per requester.
- a_bus  in  16  operand A; requester i drives bits [4i+3:4i].
- b_bus  in  16  operand B; requester i drives bits [4i+3:4i].
- gnt  out  4  one-hot grant, one-cycle pulse.
- busy  out  1  high while a compare is in flight (state CMP).
- res_valid  out  1  one-cycle pulse; result fields are valid.
- res_id  out  2  requester index the result belongs to.
- res_e  out  1  A == B.
- res_g  out  1  A > B (unsigned).
- res_l  out  1  A < B (unsigned).

## Operation
- Reset values: state IDLE, ptr=0, gnt=0000, busy=0, res_valid=0, res_id=0, res_e=res_g=res_l=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, select a winner by round-robin. The search starts at index ptr and proceeds ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
  - On the clock edge: register gnt = one-hot(winner), latch that requester's A and B nibbles into op_a and op_b, latch winner into cur_id, set busy=1, go to CMP.
- State CMP:
  - Compare op_a and op_b as unsigned values (internal magcom equivalent).
  - On the clock edge: register res_e/res_g/res_l, set res_id=cur_id, pulse res_valid=1, clear gnt and busy, set ptr=(cur_id+1) mod 4, return to IDLE.
- Exactly one of res_e, res_g, res_l is 1 whenever res_valid=1.
- The result fields hold their last values between res_valid pulses. res_valid and gnt are each high for exactly one cycle per transaction.
- req is ignored while in CMP. Operand buses are only sampled on the IDLE-to-CMP edge, so a requester may change its operands after gnt.
- Requester protocol: drop req no later than the edge after seeing gnt. A req still high when the block returns to IDLE counts as a new request and competes normally under round-robin.
- Simultaneous events: on the cycle res_valid is high the block is already in IDLE. The next arbitration occurs on that same cycle and uses the updated ptr.
- Reset mid-operation (rst high in CMP): the transaction is abandoned. No res_valid is produced, all outputs go to their reset values, ptr returns to 0.
- rst takes priority over all other activity.

## Timing
- Req sampled at edge T (IDLE) → gnt and busy high during cycle T+1 → res_valid high during cycle T+2.
- Latency from the request-sampling edge to result: 2 cycles.
- Throughput: one compare per 2 cycles. The back-to-back grant for the next requester appears in cycle T+3.
- gnt[i] is never high on two consecutive cycles. No more than one gnt bit is ever high.
- Fairness: with all four requesters continuously requesting, grants rotate 0,1,2,3,0,… Each requester waits at most 3 other transactions (6 cycles) between grants.

## Test plan
- Reset, then single requester:
  - Stimulus: req=0001, a_bus[3:0]=0100, b_bus[3:0]=0101.
  - Required: gnt=0001 one cycle later, then res_valid with res_id=0 and res_l=1, res_e=0, res_g=0.
- Requester 2 with operands 1110 vs 1101:
  - Required: res_id=2, res_g=1.
- Requester 3 with operands 1100 vs 1100:
  - Required: res_id=3, res_e=1. Flags hold after the valid pulse.
- Round-robin with req=1111 held continuously:
  - Operand pairs: 1100/1111, 0110/0111, 1110/1101, 0000/0000 for requesters 0–3.
  - Required: grants in order 0,1,2,3,0, spaced 2 cycles apart. Results are l, l, g, e with matching res_id.
- Pointer after a grant:
  - Stimulus: grant requester 2, then assert req=0101.
  - Required: requester 0 is skipped until requester... specifically, requester 2 is served last; ptr=3 selects requester 0 first, and the next grant goes to 0, not 2.
- Reset in CMP:
  - Stimulus: assert rst during the gnt cycle.
  - Required: no res_valid, all outputs 0, ptr=0. The next request with req=1010 grants requester 1 first.
